uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 40 ++++
 rtl/uart_tx.sv | 156 +++++++++++++++
 tb/tb_uart_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: state encoding, parity modes and
//               the baud divisor rounding helper used by TX and RX blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame state encoding shared by transmitter and receiver
    localparam logic [2:0] c_STATE_IDLE   = 3'd0;
    localparam logic [2:0] c_STATE_START  = 3'd1;
    localparam logic [2:0] c_STATE_DATA   = 3'd2;
    localparam logic [2:0] c_STATE_PARITY = 3'd3;
    localparam logic [2:0] c_STATE_STOP   = 3'd4;

    // Parity modes
    localparam int c_PARITY_NONE = 0;
    localparam int c_PARITY_EVEN = 1;
    localparam int c_PARITY_ODD  = 2;

    // Clocks per bit, rounded to the nearest integer
    function automatic int calcDivisor(input int clockFrequency, input int baudRate);
        return (clockFrequency + baudRate / 2) / baudRate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-period counter. Counts 0..DIVISOR-1 and flags the last
//               clock of each bit period; a clear realigns the period.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIVISOR = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                 c_CNT_W = $clog2(DIVISOR);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIVISOR - 1);

    logic [c_CNT_W-1:0] r_count;

    // Free-running bit-period counter, restarted by clear so the next bit
    // begins on the clearing edge
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Tick marks the final clock of a bit; the bit changes on the next edge
    assign o_tick = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter. Accepts a byte on a valid/ready handshake
//               and sends start, 8 data bits LSB first, optional parity and
//               1 or 2 stop bits. Line output comes straight from a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 1_000_000,
    parameter int BAUD_RATE       = 9600,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] TxData,
    input  logic       TxValid,
    output logic       TxReady,
    output logic       TxWire,
    output logic       TxDone
);

    localparam int   c_DIVISOR   = calcDivisor(CLOCK_FREQUENCY, BAUD_RATE);
    localparam logic c_LAST_STOP = 1'(STOP_BITS - 1);

    // Reject configurations the frame logic cannot represent
    if (c_DIVISOR < 2) begin : g_badDivisor
        $error("uart_tx: baud divisor must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_badParity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_badStopBits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    logic [2:0] r_state,     w_nextState;
    logic [7:0] r_shift,     w_nextShift;
    logic [2:0] r_bitIdx,    w_nextBitIdx;
    logic       r_parityBit, w_nextParityBit;
    logic       r_stopIdx,   w_nextStopIdx;
    logic       r_txWire,    w_nextTxWire;
    logic       r_txDone,    w_nextTxDone;
    logic       w_baudClear;
    logic       w_baudTick;
    logic       w_byteParity;

    uart_baud_tick #(
        .DIVISOR (c_DIVISOR)
    ) u_baudTick (
        .clk     (Clk),
        .rst     (Reset),
        .i_clear (w_baudClear),
        .o_tick  (w_baudTick)
    );

    assign w_byteParity = ^TxData;

    // State, datapath and output registers; reset abandons any frame
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= c_STATE_IDLE;
            r_shift     <= '0;
            r_bitIdx    <= '0;
            r_parityBit <= 1'b0;
            r_stopIdx   <= 1'b0;
            r_txWire    <= 1'b1;
            r_txDone    <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_shift     <= w_nextShift;
            r_bitIdx    <= w_nextBitIdx;
            r_parityBit <= w_nextParityBit;
            r_stopIdx   <= w_nextStopIdx;
            r_txWire    <= w_nextTxWire;
            r_txDone    <= w_nextTxDone;
        end
    end

    // Next-state logic; the line level is derived from the next state so the
    // wire flop changes on the same edge as the state
    always_comb begin
        w_nextState     = r_state;
        w_nextShift     = r_shift;
        w_nextBitIdx    = r_bitIdx;
        w_nextParityBit = r_parityBit;
        w_nextStopIdx   = r_stopIdx;
        w_nextTxDone    = 1'b0;
        w_baudClear     = 1'b0;
        w_nextTxWire    = 1'b1;

        case (r_state)
            c_STATE_IDLE: begin
                if (TxValid) begin
                    // Capture the byte and restart the bit period on this edge
                    w_nextShift     = TxData;
                    w_nextParityBit = (PARITY == c_PARITY_ODD) ? ~w_byteParity : w_byteParity;
                    w_nextState     = c_STATE_START;
                    w_baudClear     = 1'b1;
                end
            end
            c_STATE_START: begin
                if (w_baudTick) begin
                    w_nextState  = c_STATE_DATA;
                    w_nextBitIdx = 3'd0;
                end
            end
            c_STATE_DATA: begin
                if (w_baudTick) begin
                    w_nextShift = {1'b0, r_shift[7:1]};
                    if (r_bitIdx == 3'd7) begin
                        w_nextStopIdx = 1'b0;
                        w_nextState   = (PARITY != c_PARITY_NONE) ? c_STATE_PARITY : c_STATE_STOP;
                    end else begin
                        w_nextBitIdx = r_bitIdx + 3'd1;
                    end
                end
            end
            c_STATE_PARITY: begin
                if (w_baudTick) begin
                    w_nextStopIdx = 1'b0;
                    w_nextState   = c_STATE_STOP;
                end
            end
            c_STATE_STOP: begin
                if (w_baudTick) begin
                    if (r_stopIdx == c_LAST_STOP) begin
                        w_nextState  = c_STATE_IDLE;
                        w_nextTxDone = 1'b1;
                    end else begin
                        w_nextStopIdx = 1'b1;
                    end
                end
            end
            default: begin
                w_nextState = c_STATE_IDLE;
            end
        endcase

        case (w_nextState)
            c_STATE_START:  w_nextTxWire = 1'b0;
            c_STATE_DATA:   w_nextTxWire = w_nextShift[0];
            c_STATE_PARITY: w_nextTxWire = w_nextParityBit;
            default:        w_nextTxWire = 1'b1;
        endcase
    end

    assign TxReady = (r_state == c_STATE_IDLE);
    assign TxWire  = r_txWire;
    assign TxDone  = r_txDone;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Three transmitter
//               configurations run side by side; stimulus pushes expected
//               frames to a queue and a line monitor decodes TxWire.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int NCFG = 3;
    localparam int CFG_CLK [NCFG] = '{1_000_000, 1_000_000, 1_000_000};
    localparam int CFG_BAUD[NCFG] = '{9600, 100_000, 83_333};
    localparam int CFG_PAR [NCFG] = '{0, 1, 2};
    localparam int CFG_STOP[NCFG] = '{1, 1, 2};

    typedef struct {
        logic [7:0] data;
        int         accept;
        int         abortAt;
        int         idx;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   fin [NCFG];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int D   = (CFG_CLK[g] + CFG_BAUD[g] / 2) / CFG_BAUD[g];
        localparam int PAR = CFG_PAR[g];
        localparam int F   = 1 + 8 + ((PAR != 0) ? 1 : 0) + CFG_STOP[g];

        logic       rst;
        logic       txValid;
        logic [7:0] txData;
        logic       txReady;
        logic       txWire;
        logic       txDone;
        exp_t       q[$];
        int         busyUntil;
        int         frameCount;
        bit         armed;

        uart_tx #(
            .CLOCK_FREQUENCY (CFG_CLK[g]),
            .BAUD_RATE       (CFG_BAUD[g]),
            .PARITY          (CFG_PAR[g]),
            .STOP_BITS       (CFG_STOP[g])
        ) u_dut (
            .Clk     (clk),
            .Reset   (rst),
            .TxData  (txData),
            .TxValid (txValid),
            .TxReady (txReady),
            .TxWire  (txWire),
            .TxDone  (txDone)
        );

        // Line level of frame bit k for byte d
        function automatic int expBit(input logic [7:0] d, input int k);
            int ones;
            ones = $countones(d);
            if (k == 0) return 0;
            if (k <= 8) return int'(d[k-1]);
            if (k == 9 && PAR == 1) return (ones % 2 == 1) ? 1 : 0;
            if (k == 9 && PAR == 2) return (ones % 2 == 0) ? 1 : 0;
            return 1;
        endfunction

        // Present a byte from a falling edge; accept edge comes from the model
        task automatic sendByte(input logic [7:0] d, input int abortAt);
            int acc;
            txValid = 1'b1;
            txData  = d;
            acc = (cyc + 1 > busyUntil + 1) ? cyc + 1 : busyUntil + 1;
            q.push_back('{data: d, accept: acc, abortAt: abortAt, idx: frameCount});
            frameCount++;
            while (cyc < acc) @(negedge clk);
            txValid = 1'b0;
            if (abortAt >= 0) begin
                while (cyc < acc + abortAt - 1) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                busyUntil = acc + abortAt;
            end else begin
                busyUntil = acc + F * D;
            end
        endtask

        // Idle gap; while busy, scramble TxData and pulse TxValid
        task automatic randomGap(input int n);
            for (int i = 0; i < n; i++) begin
                txValid = 1'b0;
                if (cyc + 1 <= busyUntil) begin
                    case ($urandom_range(0, 3))
                        0: txData = 8'($urandom);
                        1: begin
                            txValid = 1'b1;
                            txData  = 8'($urandom);
                        end
                        default: ;
                    endcase
                end
                @(negedge clk);
            end
            txValid = 1'b0;
        endtask

        initial begin : stim
            int nRand;
            int w;
            rst        = 1'b1;
            txValid    = 1'b0;
            txData     = 8'h00;
            armed      = 1'b0;
            frameCount = 0;
            repeat (3) @(negedge clk);
            check($sformatf("cfg%0d_reset_wire", g), int'(txWire), 1);
            check($sformatf("cfg%0d_reset_ready", g), int'(txReady), 1);
            check($sformatf("cfg%0d_reset_done", g), int'(txDone), 0);
            rst       = 1'b0;
            busyUntil = cyc;
            armed     = 1'b1;

            if (g == 0) begin
                sendByte(8'h55, -1);
                randomGap(3);
                sendByte(8'hA5, -1);
                sendByte(8'h3C, -1);
                randomGap(5);
                sendByte(8'h00, 4 * D + D / 2);
                randomGap(10);
                sendByte(8'h81, -1);
                nRand = 4;
            end else begin
                sendByte(8'h03, -1);
                randomGap(2);
                sendByte((g == 1) ? 8'h07 : 8'hFF, -1);
                nRand = 16;
            end

            for (int i = 0; i < nRand; i++) begin
                if ($urandom_range(0, 3) != 0) randomGap($urandom_range(1, F * D + 4));
                sendByte(8'($urandom), -1);
            end

            w = 0;
            while ((q.size() != 0 || cyc <= busyUntil + 2) && w < 20000) begin
                @(negedge clk);
                w++;
            end
            check($sformatf("cfg%0d_drain", g), q.size(), 0);
            fin[g] = 1'b1;
        end

        initial begin : mon
            exp_t e;
            int   busyBad;
            int   k;
            int   expv;
            int   obs;
            wait (armed);
            forever begin
                @(negedge clk);
                if (txDone) check($sformatf("cfg%0d_spurious_done", g), int'(txDone), 0);
                if (txWire == 1'b0) begin
                    if (q.size() == 0) begin
                        check($sformatf("cfg%0d_unexpected_start", g), 1, 0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("cfg%0d_f%0d_start_cycle", g, e.idx), cyc, e.accept);
                        busyBad = 0;
                        expv    = 0;
                        obs     = 0;
                        for (int t = 0; t <= F * D; t++) begin
                            if (t != 0) @(negedge clk);
                            if (e.abortAt >= 0 && t == e.abortAt) begin
                                check($sformatf("cfg%0d_f%0d_abort_wire", g, e.idx), int'(txWire), 1);
                                check($sformatf("cfg%0d_f%0d_abort_ready", g, e.idx), int'(txReady), 1);
                                check($sformatf("cfg%0d_f%0d_abort_done", g, e.idx), int'(txDone), 0);
                                break;
                            end
                            if (t == F * D) begin
                                check($sformatf("cfg%0d_f%0d_done_pulse", g, e.idx), int'(txDone), 1);
                                check($sformatf("cfg%0d_f%0d_ready_after", g, e.idx), int'(txReady), 1);
                                check($sformatf("cfg%0d_f%0d_idle_wire", g, e.idx), int'(txWire), 1);
                            end else begin
                                k = t / D;
                                if (t % D == 0) begin
                                    expv = expBit(e.data, k);
                                    obs  = expv;
                                end
                                if (int'(txWire) != expv && obs == expv) obs = int'(txWire);
                                if (txReady != 1'b0 || txDone != 1'b0) busyBad++;
                                if (t % D == D - 1)
                                    check($sformatf("cfg%0d_f%0d_bit%0d", g, e.idx, k), obs, expv);
                            end
                        end
                        check($sformatf("cfg%0d_f%0d_busy_flags", g, e.idx), busyBad, 0);
                    end
                end
            end
        end
    end

    initial begin : main
        int w;
        w = 0;
        while (!(fin[0] && fin[1] && fin[2]) && w < 95000) begin
            @(negedge clk);
            w++;
        end
        if (!(fin[0] && fin[1] && fin[2])) check("global_timeout", 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
